// File: rtl/digit_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : digit_display_ctrl                                         |
// | Description : binary->BCD shift-add-3 engine, frame-synchronous digit    |
// |               double buffer, and keyed digit-sprite pixel generator.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module digit_display_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14,
   parameter int X0         = 16,
   parameter int Y0         = 8,
   parameter int KEY_COLOR  = 391
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [VALUE_W-1:0] value,
   input  logic               value_load,
   input  logic               frame_start,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   output logic [3:0]         sprite_digit,
   output logic [4:0]         sprite_row,
   output logic [4:0]         sprite_col,
   input  logic [8:0]         sprite_rgb,
   output logic               pix_en,
   output logic [8:0]         pix_rgb,
   output logic               busy,
   output logic               pending_valid
);

   localparam int c_BCD_W   = 4 * NUM_DIGITS;
   localparam int c_CNT_W   = $clog2(VALUE_W + 1);
   localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int c_MAX_INT = 10 ** NUM_DIGITS - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_start;
   logic                 w_shift;
   logic                 w_done_wr;
   logic                 w_commit;
   logic [VALUE_W-1:0]   w_clamped;
   logic [c_BCD_W-1:0]   w_bcd_adj;
   logic [VALUE_W-1:0]   r_bin;
   logic [c_BCD_W-1:0]   r_bcd;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_BCD_W-1:0]   r_pending;
   logic [c_BCD_W-1:0]   r_shown;
   logic                 r_pending_valid;
   logic                 r_pix_en;
   logic [8:0]           r_pix_rgb;

   // Larger inputs saturate to all nines rather than wrapping.
   assign w_clamped = (32'(value) > 32'(c_MAX_INT)) ? VALUE_W'(c_MAX_INT) : value;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_done_wr    = 1'b0;
      if (value_load) begin
         w_start      = 1'b1;
         w_state_next = S_CONV;
      end else begin
         case (r_state)
            S_IDLE: w_state_next = S_IDLE;
            S_CONV: begin
               w_shift = 1'b1;
               if (r_cnt == c_CNT_W'(VALUE_W - 1)) w_state_next = S_DONE;
            end
            S_DONE: begin
               w_done_wr    = 1'b1;
               w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // A frame_start coinciding with the result write is deliberately ignored.
   assign w_commit = frame_start && r_pending_valid && !w_done_wr;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_bin           <= '0;
         r_bcd           <= '0;
         r_cnt           <= '0;
         r_pending       <= '0;
         r_shown         <= '0;
         r_pending_valid <= 1'b0;
      end else begin
         if (w_start) begin
            r_bin <= w_clamped;
            r_bcd <= '0;
            r_cnt <= '0;
         end else if (w_shift) begin
            {r_bcd, r_bin} <= {w_bcd_adj[c_BCD_W-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + 1'b1;
         end
         if (w_done_wr) r_pending <= r_bcd;
         if (w_done_wr)     r_pending_valid <= 1'b1;
         else if (w_commit) r_pending_valid <= 1'b0;
         if (w_commit) r_shown <= r_pending;
      end
   end

   logic [9:0]         w_rel_x;
   logic [9:0]         w_rel_y;
   logic               w_in_region;
   logic [c_IDX_W-1:0] w_idx;
   logic [3:0]         w_digits [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] w_blank;
   logic               w_zero_run;
   logic               w_draw;

   assign w_rel_x     = DrawX - 10'(X0);
   assign w_rel_y     = DrawY - 10'(Y0);
   assign w_in_region = (w_rel_x < 10'(32 * NUM_DIGITS)) && (w_rel_y < 10'd24);
   assign w_idx       = w_rel_x[5 +: c_IDX_W];

   // Index 0 is the most significant digit; the last digit is never blanked.
   always_comb begin
      w_zero_run = 1'b1;
      w_blank    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_digits[i] = r_shown[c_BCD_W-4-4*i +: 4];
         w_zero_run  = w_zero_run && (w_digits[i] == 4'd0);
         w_blank[i]  = w_zero_run && (i != NUM_DIGITS - 1);
      end
   end

   assign sprite_digit = w_in_region ? w_digits[w_idx] : 4'd0;
   assign sprite_row   = w_in_region ? w_rel_y[4:0] : 5'd0;
   assign sprite_col   = w_in_region ? w_rel_x[4:0] : 5'd0;
   assign w_draw       = w_in_region && !w_blank[w_idx] && (sprite_rgb != 9'(KEY_COLOR));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pix_en  <= 1'b0;
         r_pix_rgb <= '0;
      end else begin
         r_pix_en  <= w_draw;
         r_pix_rgb <= w_draw ? sprite_rgb : 9'd0;
      end
   end

   assign pix_en        = r_pix_en;
   assign pix_rgb       = r_pix_rgb;
   assign busy          = (r_state != S_IDLE);
   assign pending_valid = r_pending_valid;

endmodule
`default_nettype wire

// File: tb/tb_digit_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_digit_display_ctrl                                      |
// | Description : directed self-checking bench for digit_display_ctrl.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_digit_display_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [13:0] value = '0;
   logic        value_load = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic [3:0]  sprite_digit;
   logic [4:0]  sprite_row;
   logic [4:0]  sprite_col;
   logic [8:0]  sprite_rgb;
   logic        pix_en;
   logic [8:0]  pix_rgb;
   logic        busy;
   logic        pending_valid;

   int total = 0;
   int bad   = 0;
   int exp_d [4];

   digit_display_ctrl dut (
      .Clk(Clk), .Reset(Reset), .value(value), .value_load(value_load),
      .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
      .sprite_digit(sprite_digit), .sprite_row(sprite_row), .sprite_col(sprite_col),
      .sprite_rgb(sprite_rgb), .pix_en(pix_en), .pix_rgb(pix_rgb),
      .busy(busy), .pending_valid(pending_valid)
   );

   always #5 Clk = ~Clk;

   // ROM stand-in: key colour on a diagonal pattern, otherwise digit/column coded.
   function automatic int rom(input int d, input int r, input int c);
      if (((r + c) % 5) == 0) return 391;
      return d * 32 + c;
   endfunction

   always_comb sprite_rgb = 9'(rom(int'(sprite_digit), int'(sprite_row), int'(sprite_col)));

   task automatic do_load(input int v);
      @(negedge Clk);
      value      = 14'(v);
      value_load = 1'b1;
      @(negedge Clk);
      value_load = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge Clk);
      end
   endtask

   task automatic pulse_frame();
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
   endtask

   task automatic test_pixels(input string tag);
      int ys [5];
      ys = '{7, 8, 13, 31, 32};
      for (int yi = 0; yi < 5; yi++) begin
         for (int x = 10; x < 150; x++) begin
            int rx, ry, idx, ed, er, ec, ergb;
            bit inr, blank, een;
            @(negedge Clk);
            DrawX = 10'(x);
            DrawY = 10'(ys[yi]);
            rx  = x - 16;
            ry  = ys[yi] - 8;
            inr = (rx >= 0) && (rx < 128) && (ry >= 0) && (ry < 24);
            idx = inr ? rx / 32 : 0;
            blank = (idx != 3);
            for (int j = 0; j <= idx; j++) if (exp_d[j] != 0) blank = 1'b0;
            ed   = inr ? exp_d[idx] : 0;
            er   = inr ? ry : 0;
            ec   = inr ? rx % 32 : 0;
            ergb = rom(ed, er, ec);
            een  = inr && !blank && (ergb != 391);
            #1;
            total++;
            if ({sprite_digit, sprite_row, sprite_col} !== {4'(ed), 5'(er), 5'(ec)}) begin
               bad++;
               $display("FAIL %s sprite_sel x=%0d y=%0d got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d",
                        tag, x, ys[yi], sprite_digit, sprite_row, sprite_col, ed, er, ec);
            end
            @(posedge Clk);
            #1;
            total++;
            if (pix_en !== een || pix_rgb !== (een ? 9'(ergb) : 9'd0)) begin
               bad++;
               $display("FAIL %s pix x=%0d y=%0d got en=%0b rgb=%0d want en=%0b rgb=%0d",
                        tag, x, ys[yi], pix_en, pix_rgb, een, een ? ergb : 0);
            end
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
      total++;
      if (pending_valid !== 1'b0) begin bad++; $display("FAIL reset_pending got %0b want 0", pending_valid); end
      total++;
      if (pix_en !== 1'b0 || pix_rgb !== 9'd0) begin
         bad++; $display("FAIL reset_pix got en=%0b rgb=%0d want 0/0", pix_en, pix_rgb);
      end
      Reset = 1'b0;
      exp_d = '{0, 0, 0, 0};
      test_pixels("reset");
   endtask

   task automatic test_convert();
      int n;
      do_load(1234);
      wait_idle(n);
      total++;
      if (n !== 15) begin bad++; $display("FAIL conv_busy_cycles got %0d want 15", n); end
      total++;
      if (pending_valid !== 1'b1) begin bad++; $display("FAIL conv_pending got %0b want 1", pending_valid); end
      pulse_frame();
      total++;
      if (pending_valid !== 1'b0) begin bad++; $display("FAIL conv_commit_clear got %0b want 0", pending_valid); end
      exp_d = '{1, 2, 3, 4};
      test_pixels("v1234");
   endtask

   task automatic test_saturate();
      int n;
      do_load(16383);
      wait_idle(n);
      total++;
      if (n !== 15) begin bad++; $display("FAIL sat_busy_cycles got %0d want 15", n); end
      pulse_frame();
      exp_d = '{9, 9, 9, 9};
      test_pixels("v16383");
   endtask

   task automatic test_back_to_back();
      int n;
      do_load(7);
      repeat (2) @(negedge Clk);
      do_load(42);
      wait_idle(n);
      total++;
      if (n !== 15) begin bad++; $display("FAIL b2b_busy_cycles got %0d want 15", n); end
      total++;
      if (pending_valid !== 1'b1) begin bad++; $display("FAIL b2b_pending got %0b want 1", pending_valid); end
      pulse_frame();
      exp_d = '{0, 0, 4, 2};
      test_pixels("v42");
   endtask

   task automatic test_done_collision();
      int n;
      do_load(5678);
      repeat (14) @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      total++;
      if (pending_valid !== 1'b1) begin bad++; $display("FAIL coll_pending got %0b want 1", pending_valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL coll_busy got %0b want 0", busy); end
      test_pixels("coll_hold");
      pulse_frame();
      total++;
      if (pending_valid !== 1'b0) begin bad++; $display("FAIL coll_commit_clear got %0b want 0", pending_valid); end
      exp_d = '{5, 6, 7, 8};
      test_pixels("v5678");
      wait_idle(n);
   endtask

   task automatic test_reset_mid_conv();
      do_load(999);
      repeat (5) @(negedge Clk);
      Reset = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %0b want 0", busy); end
      total++;
      if (pending_valid !== 1'b0) begin bad++; $display("FAIL midrst_pending got %0b want 0", pending_valid); end
      @(negedge Clk);
      Reset = 1'b0;
      repeat (20) @(negedge Clk);
      total++;
      if (pending_valid !== 1'b0) begin bad++; $display("FAIL midrst_late_pending got %0b want 0", pending_valid); end
      pulse_frame();
      exp_d = '{0, 0, 0, 0};
      test_pixels("midrst");
   endtask

   initial begin
      test_reset();
      test_convert();
      test_saturate();
      test_back_to_back();
      test_done_collision();
      test_reset_mid_conv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
